seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor, one quotient bit resolved per clock.
It is the inverse companion of the 2x2 combinational multiplier experiment: products {f3..f0} fed back with one factor as divisor must return the other factor with zero remainder.
It uses a start/busy/done handshake so it drops into the lab top-levels and a self-checking testbench loop.

Parameters:
WIDTH, 4, bit width of dividend, divisor, quotient and remainder (legal range 2..16).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE.
dividend  input  WIDTH  unsigned numerator; captured on the accepting edge.
divisor  input  WIDTH  unsigned denominator; captured on the accepting edge.
busy  output  1  high while a division is in progress.
done  output  1  one-cycle pulse when results become valid.
quotient  output  WIDTH  result quotient; held until the next completion.
remainder  output  WIDTH  result remainder; held until the next completion.
div_by_zero  output  1  set with done when the captured divisor is 0; held with the results.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and working registers cleared.
- Reset asserted mid-division aborts the operation immediately, with no done pulse.
- States: IDLE, CALC, DBZ.
- IDLE, start=1 at edge k:
  - Latch dividend into shift register Q and divisor into D; clear partial remainder R (WIDTH+1 bits); counter=0.
  - If the divisor is 0, go to DBZ; otherwise go to CALC.
  - busy=1 from edge k.
- IDLE, start=0: stay in IDLE; outputs hold.
- CALC, each edge:
  - {R,Q} shifted left 1; trial = R - {0,D}.
  - If trial is non-negative, R=trial and Q[0]=1; else R unchanged and Q[0]=0.
  - counter increments.
- CALC completion, on the WIDTH-th CALC edge (edge k+WIDTH):
  - quotient=Q result, remainder=R[WIDTH-1:0], div_by_zero=0.
  - done=1, busy=0, state=IDLE.
- DBZ, edge k+1: quotient=all ones, remainder=captured dividend, div_by_zero=1, done=1, busy=0, state=IDLE.
- done: high for exactly one cycle, cleared at the following edge unless another completion occurs.
- Latency: done visible after edge k+WIDTH (normal) or k+1 (divide by zero).
- start while busy: ignored; operand inputs are don't-care after capture.
- start high in the cycle done is high: the FSM is already in IDLE, so the new operation is accepted at that edge. done still clears and the previous results hold until the new completion.
- Back-to-back throughput: one division per WIDTH+1 cycles.
- Arithmetic: purely unsigned; no overflow is possible. Remainder is always < divisor when divisor ≠ 0.
- Held outputs (quotient, remainder, div_by_zero) change only on a completion edge or reset.

Decomposition:
- Shared package divider_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DBZ=2'd2;
  - DBZ_QUOTIENT constant (all ones, derived from WIDTH).
- One sub-module is natural: div_step.
  - Combinational single restoring iteration.
  - Inputs: R, Q msb, D. Outputs: next R, quotient bit.
  - Instantiated once inside the FSM datapath.

Test Plan:
- WIDTH=4, reset, then start with 9/3 -> busy=1 for 4 cycles; done pulse after edge k+4 with quotient=3, remainder=0, div_by_zero=0.
- 15/4 -> quotient=3, remainder=3; 2/5 -> quotient=0, remainder=2; 0/7 -> quotient=0, remainder=0.
- 7/0 -> done after edge k+1 with quotient=15, remainder=7, div_by_zero=1. A following 6/2 returns quotient=3, remainder=0, div_by_zero=0.
- Start 12/5, then pulse start with 1/1 at edge k+2 -> second request ignored. Result quotient=2, remainder=2; exactly one done pulse.
- Start 13/2, then assert rst_n=0 at edge k+2 -> all outputs 0 immediately, no done. After release, 13/2 -> quotient=6, remainder=1.
- Multiplier round-trip loop, i=0..15 with {a,b,c,d}=i and p={a,b}*{c,d} (table 0,0,0,0,0,1,2,3,0,2,4,6,0,3,6,9):
  - divisor {c,d}≠0: p/{c,d} -> quotient={a,b}, remainder=0, printing TRUE/FALSE per vector;
  - divisor 0: div_by_zero=1.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// divider_pkg: shared FSM encoding and constants for the sequential restoring divider
package divider_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DBZ = 2'd2} state_t;
  localparam int MAX_WIDTH = 16;
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;
endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// div_step: one combinational restoring iteration (shift in next dividend bit, trial subtract)
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  // one guard bit above the shifted remainder makes the trial's msb a clean borrow flag
  always_comb begin
    shifted = {r, q_msb};
    trial   = shifted - {2'b0, d};
    q_bit   = ~trial[WIDTH+1];
    r_next  = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per clock, start/busy/done handshake
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [4:0] LAST = 5'(WIDTH - 1);
  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_next;
  logic             q_bit;
  logic [4:0]       cnt;
  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q_msb  (q[WIDTH-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );
  // q doubles as the dividend shifter: its msb feeds the step while quotient bits enter at the lsb
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          q     <= dividend;
          d     <= divisor;
          r     <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= (divisor == '0) ? ST_DBZ : ST_CALC;
        end
        ST_CALC: begin
          r   <= r_next;
          q   <= {q[WIDTH-2:0], q_bit};
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            quotient    <= {q[WIDTH-2:0], q_bit};
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_DBZ: begin
          quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
          remainder   <= q;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: vector table, random and corner-case sequences against an arithmetic model
module tb_seq_restoring_divider;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  int           errors = 0;
  int           checks = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // issue a request at the next edge and leave inputs idle after it
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom_range(0, 15);
    divisor = $urandom_range(0, 15);
  endtask

  // count edges from acceptance to done and compare results
  task automatic finish(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input int skipped);
    int cyc = skipped;
    int lat = (b == 0) ? 1 : W;
    logic [W-1:0] eq = (b == 0) ? 4'hF : a / b;
    logic [W-1:0] er = (b == 0) ? a : a % b;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    check({name, " latency"}, cyc, lat);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " dbz"}, div_by_zero, b == 0);
    check({name, " busy_clear"}, busy, 0);
  endtask

  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    check({name, " busy_set"}, busy, 1);
    finish(name, a, b, 0);
    @(posedge clk);
    #1;
    check({name, " done_pulse"}, done, 0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{4'd9, 4'd3, 4'd3, 4'd0, 1'b0};
    vecs[1] = '{4'd15, 4'd4, 4'd3, 4'd3, 1'b0};
    vecs[2] = '{4'd2, 4'd5, 4'd0, 4'd2, 1'b0};
    vecs[3] = '{4'd0, 4'd7, 4'd0, 4'd0, 1'b0};
    vecs[4] = '{4'd7, 4'd0, 4'd15, 4'd7, 1'b1};
    vecs[5] = '{4'd6, 4'd2, 4'd3, 4'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d table_q", i), quotient, vecs[i].eq);
      check($sformatf("vec%0d table_r", i), remainder, vecs[i].er);
      check($sformatf("vec%0d table_z", i), div_by_zero, vecs[i].ez);
    end

    for (int i = 0; i < 30; i++)
      run($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // second request during a busy division is ignored
    issue(4'd12, 4'd5);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd1;
    divisor = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish("ignore", 4'd12, 4'd5, 2);
    begin
      int extra = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      check("ignore extra_done", extra, 0);
      check("ignore held_q", quotient, 2);
    end

    // start accepted in the cycle done is high; previous results hold meanwhile
    issue(4'd9, 4'd4);
    finish("b2b first", 4'd9, 4'd4, 0);
    issue(4'd14, 4'd3);
    check("b2b accept busy", busy, 1);
    check("b2b done_clear", done, 0);
    check("b2b held_q", quotient, 2);
    check("b2b held_r", remainder, 1);
    finish("b2b second", 4'd14, 4'd3, 0);

    // asynchronous reset aborts a division
    issue(4'd13, 4'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort dbz", div_by_zero, 0);
    begin
      int seen = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (done) seen++;
      end
      check("abort no_done", seen, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run("after_abort", 4'd13, 4'd2);

    // multiplier round-trip: product divided by one factor gives back the other
    for (int i = 0; i < 16; i++) begin
      logic [1:0] ab = 2'(i >> 2);
      logic [1:0] cd = 2'(i);
      logic [3:0] p = 4'(ab * cd);
      run($sformatf("mul%0d", i), p, {2'b0, cd});
      if (cd != 0) begin
        check($sformatf("mul%0d factor", i), quotient, {2'b0, ab});
        $display("mul %0d: %0d/%0d -> %0d r%0d %s", i, p, cd, quotient, remainder,
                 (quotient == {2'b0, ab} && remainder == 0) ? "TRUE" : "FALSE");
      end else begin
        check($sformatf("mul%0d dbz_flag", i), div_by_zero, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
